// File: rtl/rca_sum_arbiter.sv
// rca_sum_arbiter: shares one 3-operand ripple-carry sum datapath (a+b+c)
// among NUM_REQ requesters. One transaction is outstanding at a time:
// IDLE (grant and capture) -> ADD (register sum) -> RESP (valid/ready result).
//
// Build option:
//   RCA_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins, no rr_ptr
//                          undefined -> round-robin starting at rr_ptr (default)
module rca_sum_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned W       = 8,
  parameter int unsigned SUM_W   = W + 3,
  parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*W-1:0] req_a,
  input  logic [NUM_REQ*W-1:0] req_b,
  input  logic [NUM_REQ*W-1:0] req_c,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [SUM_W-1:0]     res_sum,
  output logic [ID_W-1:0]      res_id,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       op_a_q, op_a_d;
  logic [W-1:0]       op_b_q, op_b_d;
  logic [W-1:0]       op_c_q, op_c_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [SUM_W-1:0]   res_sum_q, res_sum_d;
  logic [ID_W-1:0]    res_id_q, res_id_d;
  logic               res_valid_q, res_valid_d;
  logic               busy_q, busy_d;

  logic               win_found;
  logic [ID_W-1:0]    win_idx;
  logic [NUM_REQ-1:0] win_onehot;
  logic [W-1:0]       sel_a, sel_b, sel_c;
  logic               transfer;

`ifdef RCA_ARB_FIXED_PRIO_EN
  // Winner search: lowest requester index with valid set
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_valid[ID_W'(i)]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(i);
      end
    end
  end
`else
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  // Winner search: first valid requester starting at rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    int unsigned cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(rr_ptr_q) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!win_found && req_valid[ID_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(cand);
      end
    end
  end
`endif

  // One-hot decode of the winner and selection of its operand triple
  always_comb begin
    win_onehot = '0;
    sel_a      = '0;
    sel_b      = '0;
    sel_c      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_idx == ID_W'(i)) begin
        win_onehot[i] = win_found;
        sel_a         = req_a[i*W +: W];
        sel_b         = req_b[i*W +: W];
        sel_c         = req_c[i*W +: W];
      end
    end
  end

  // State and datapath registers; reset aborts any in-flight transaction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_c_q      <= '0;
      id_q        <= '0;
      res_sum_q   <= '0;
      res_id_q    <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifndef RCA_ARB_FIXED_PRIO_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_c_q      <= op_c_d;
      id_q        <= id_d;
      res_sum_q   <= res_sum_d;
      res_id_q    <= res_id_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
`ifndef RCA_ARB_FIXED_PRIO_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (transfer)  state_d = ST_ADD;
      ST_ADD:                 state_d = ST_RESP;
      ST_RESP: if (res_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: grant only in IDLE and never while reset is asserted
  always_comb begin
    req_ready = '0;
    if ((state_q == ST_IDLE) && !reset) begin
      req_ready = win_onehot;
    end
    transfer = |(req_valid & req_ready);
  end

  // Datapath next values: capture on transfer, sum in ADD, hold through RESP
  always_comb begin
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_c_d      = op_c_q;
    id_d        = id_q;
    res_sum_d   = res_sum_q;
    res_id_d    = res_id_q;
`ifndef RCA_ARB_FIXED_PRIO_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    if (transfer) begin
      op_a_d = sel_a;
      op_b_d = sel_b;
      op_c_d = sel_c;
      id_d   = win_idx;
`ifndef RCA_ARB_FIXED_PRIO_EN
      rr_ptr_d = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
`endif
    end
    if (state_q == ST_ADD) begin
      res_sum_d = SUM_W'(op_a_q) + SUM_W'(op_b_q) + SUM_W'(op_c_q);
      res_id_d  = id_q;
    end
    res_valid_d = (state_d == ST_RESP);
    busy_d      = (state_d != ST_IDLE);
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_id    = res_id_q;
  assign busy      = busy_q;

  // Grant is never more than one requester
  a_ready_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));

  // Three W-bit operands never reach the top result bit
  a_sum_msb_zero: assert property (@(posedge clk) disable iff (reset) !res_sum[SUM_W-1]);

  // A stalled result stays valid and stable
  a_resp_hold: assert property (@(posedge clk) disable iff (reset)
    (res_valid && !res_ready) |=> (res_valid && $stable(res_sum) && $stable(res_id)));

endmodule

// File: tb/tb_rca_sum_arbiter.sv
// Directed bench for rca_sum_arbiter with hand-computed expected values.
module tb_rca_sum_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned W       = 8;
  localparam int unsigned SUM_W   = W + 3;
  localparam int unsigned ID_W    = 2;

  logic                 clk;
  logic                 reset;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*W-1:0] req_a;
  logic [NUM_REQ*W-1:0] req_b;
  logic [NUM_REQ*W-1:0] req_c;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 res_valid;
  logic                 res_ready;
  logic [SUM_W-1:0]     res_sum;
  logic [ID_W-1:0]      res_id;
  logic                 busy;

  int unsigned n_checks;
  int unsigned n_errors;

  int exp_order [5];
  int exp_rr_sum [4];

  rca_sum_arbiter #(
    .NUM_REQ (NUM_REQ),
    .W       (W),
    .SUM_W   (SUM_W),
    .ID_W    (ID_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_id    (res_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next falling edge
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_ops(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c);
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_c[id*W +: W] = c;
  endtask

  // Single-requester transaction with res_ready high
  task automatic run_txn(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input int exp_sum);
    set_ops(id, a, b, c);
    req_valid = NUM_REQ'(32'(1) << id);
    #1;
    check("grant", 32'(req_ready), 32'(1) << id);
    check("idle_busy", 32'(busy), 0);
    step();
    req_valid = '0;
    check("add_ready", 32'(req_ready), 0);
    check("add_busy", 32'(busy), 1);
    check("add_valid", 32'(res_valid), 0);
    step();
    check("resp_valid", 32'(res_valid), 1);
    check("resp_sum", 32'(res_sum), 32'(exp_sum));
    check("resp_id", 32'(res_id), 32'(id));
    check("resp_busy", 32'(busy), 1);
    check("resp_msb", 32'(res_sum[SUM_W-1]), 0);
    step();
    check("done_valid", 32'(res_valid), 0);
    check("done_busy", 32'(busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int  t;
    bit  got;
    n_checks  = 0;
    n_errors  = 0;
    t         = 0;
    got       = 1'b0;
`ifdef RCA_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    // req i uses a=10*i+1, b=2, c=3
    exp_rr_sum = '{6, 16, 26, 36};
    reset     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_c     = '0;
    res_ready = 1'b1;

    // Reset values
    #1 reset = 1'b1;
    #1;
    check("rst_ready", 32'(req_ready), 0);
    check("rst_valid", 32'(res_valid), 0);
    check("rst_sum", 32'(res_sum), 0);
    check("rst_id", 32'(res_id), 0);
    check("rst_busy", 32'(busy), 0);
    step();
    step();
    reset = 1'b0;

    // Single request, max operands, carry case
    run_txn(0, 8'd1, 8'd2, 8'd3, 6);
    run_txn(2, 8'd255, 8'd255, 8'd255, 765);
    run_txn(1, 8'd255, 8'd1, 8'd0, 256);

    // All requesters valid from reset, res_ready high
    reset = 1'b1;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      set_ops(i, W'(10 * i + 1), 8'd2, 8'd3);
    end
    req_valid = '1;
    step();
    reset = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      got = 1'b0;
      t   = 0;
      while (!got && t < 10) begin
        if (req_ready != '0) got = 1'b1;
        else begin
          step();
          t++;
        end
      end
      check("rr_wait", 32'(got), 1);
      if (k > 0) check("rr_gap", 32'(t), 0);
      check("rr_grant", 32'(req_ready), 32'(1) << exp_order[k]);
      step();
      step();
      check("rr_valid", 32'(res_valid), 1);
      check("rr_id", 32'(res_id), 32'(exp_order[k]));
      check("rr_sum", 32'(res_sum), 32'(exp_rr_sum[exp_order[k]]));
      if (k == 4) req_valid = '0;
      step();
    end
    check("rr_end_ready", 32'(req_ready), 0);
    check("rr_end_busy", 32'(busy), 0);

    // Backpressure: 7+8+9 from req 3 stalls while req 1 waits
    res_ready = 1'b0;
    set_ops(3, 8'd7, 8'd8, 8'd9);
    req_valid = 4'b1000;
    #1;
    check("bp_grant", 32'(req_ready), 32'h8);
    step();
    set_ops(1, 8'd100, 8'd20, 8'd3);
    req_valid = 4'b0010;
    #1;
    check("bp_add_ready", 32'(req_ready), 0);
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(res_valid), 1);
      check("bp_sum", 32'(res_sum), 24);
      check("bp_id", 32'(res_id), 3);
      check("bp_ready", 32'(req_ready), 0);
      step();
    end
    res_ready = 1'b1;
    #1;
    check("bp_rel_ready", 32'(req_ready), 0);
    check("bp_rel_valid", 32'(res_valid), 1);
    step();
    check("bp_next_grant", 32'(req_ready), 32'h2);
    check("bp_next_valid", 32'(res_valid), 0);
    step();
    req_valid = '0;
    step();
    check("bp2_valid", 32'(res_valid), 1);
    check("bp2_sum", 32'(res_sum), 123);
    check("bp2_id", 32'(res_id), 1);
    step();
    check("bp2_done", 32'(res_valid), 0);

    // Reset in ADD aborts the transaction; reissue completes
    set_ops(0, 8'd123, 8'd45, 8'd67);
    req_valid = 4'b0001;
    #1;
    check("ra_grant", 32'(req_ready), 32'h1);
    step();
    check("ra_add_busy", 32'(busy), 1);
    check("ra_add_valid", 32'(res_valid), 0);
    #2 reset = 1'b1;
    #1;
    check("ra_rst_ready", 32'(req_ready), 0);
    check("ra_rst_valid", 32'(res_valid), 0);
    check("ra_rst_sum", 32'(res_sum), 0);
    check("ra_rst_id", 32'(res_id), 0);
    check("ra_rst_busy", 32'(busy), 0);
    step();
    check("ra_hold_valid", 32'(res_valid), 0);
    check("ra_hold_ready", 32'(req_ready), 0);
    reset = 1'b0;
    run_txn(0, 8'd123, 8'd45, 8'd67, 235);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
